// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin owner of the framebuffer write port with a built-in clear sequencer
module fb_write_arbiter #(
  parameter int N_REQ = 3,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 4,
  parameter int DEPTH = 512,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  input  logic [N_REQ*DATA_W-1:0]  req_we,
  input  logic                     clear_req,
  output logic [N_REQ-1:0]         gnt,
  output logic                     clear_busy,
  output logic [ADDR_W-1:0]        fb_addr,
  output logic [DATA_W-1:0]        fb_data,
  output logic [DATA_W-1:0]        fb_we
);
  localparam int PW = $clog2(N_REQ);
  localparam logic [1:0] S_CLEAR = 2'd0, S_IDLE = 2'd1, S_GRANT = 2'd2;
  logic [1:0] state;
  logic [ADDR_W-1:0] clr_ctr;
  logic [PW-1:0] rr_ptr, owner, win, win_hi, win_lo;
  logic hit_hi, clear_pend;
  assign win = hit_hi ? win_hi : win_lo;
  assign clear_busy = (state == S_CLEAR) || clear_pend;
  // round-robin pick: lowest requester at or above rr_ptr, otherwise wrap to the lowest one
  always_comb begin
    win_hi = '0;
    win_lo = '0;
    hit_hi = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) win_lo = PW'(i);
      if (req[i] && PW'(i) >= rr_ptr) begin
        win_hi = PW'(i);
        hit_hi = 1'b1;
      end
    end
  end
  // clear sequencing, burst ownership and the registered framebuffer write port
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_CLEAR;
      clr_ctr <= '0;
      rr_ptr <= '0;
      owner <= '0;
      clear_pend <= 1'b0;
      gnt <= '0;
      fb_addr <= '0;
      fb_data <= '0;
      fb_we <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          fb_addr <= clr_ctr;
          fb_data <= CLR_VAL;
          fb_we <= '1;
          clr_ctr <= (clr_ctr == ADDR_W'(DEPTH - 1)) ? '0 : clr_ctr + 1'b1;
          if (clr_ctr == ADDR_W'(DEPTH - 1)) begin
            clear_pend <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          fb_we <= '0;
          if (clear_req || clear_pend) state <= S_CLEAR;
          else if (|req) begin
            gnt <= N_REQ'(1) << win;
            owner <= win;
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (clear_req) clear_pend <= 1'b1;
          if (req[owner]) begin
            fb_addr <= req_addr[owner*ADDR_W +: ADDR_W];
            fb_data <= req_data[owner*DATA_W +: DATA_W];
            fb_we <= req_we[owner*DATA_W +: DATA_W];
          end else begin
            gnt <= '0;
            fb_we <= '0;
            rr_ptr <= (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end
endmodule
